// File: rtl/lgp_pkg.sv
// lgp_pkg: op codes, field widths and pipe states shared by logic_gate_pipe and lgp_reduce
package lgp_pkg;
    localparam int OP_W  = 3;
    localparam int CNT_W = 16;
    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    typedef enum logic {EMPTY, FULL} state_e;
endpackage

// File: rtl/lgp_reduce.sv
// lgp_reduce: combinational bitwise reduction of NUM_IN operands selected by op; reserved ops give zero
module lgp_reduce
    import lgp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  logic [OP_W-1:0]         op,
    input  logic [NUM_IN*WIDTH-1:0] x,
    output logic [WIDTH-1:0]        z,
    output logic                    bad_op
);
    logic [WIDTH-1:0] a, o, e;
    always_comb begin
        a = x[WIDTH-1:0];
        o = x[WIDTH-1:0];
        e = x[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            a = a & x[k*WIDTH +: WIDTH];
            o = o | x[k*WIDTH +: WIDTH];
            e = e ^ x[k*WIDTH +: WIDTH];
        end
        z = op == OP_AND  ? a  :
            op == OP_OR   ? o  :
            op == OP_XOR  ? e  :
            op == OP_NAND ? ~a :
            op == OP_NOR  ? ~o :
            op == OP_XNOR ? ~e : '0;
    end
    assign bad_op = op > OP_XNOR;
endmodule

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: 1-cycle registered bitwise gate with valid/ready; txn_cnt exists only with LOGIC_GATE_PIPE_STATS_EN
module logic_gate_pipe
    import lgp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         op,
    input  logic [NUM_IN*WIDTH-1:0] x,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        z,
    output logic                    z_all,
    output logic                    z_any,
    output logic                    err
`ifdef LOGIC_GATE_PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0]        txn_cnt
`endif
);
    state_e state, nxt;
    logic [WIDTH-1:0] rz;
    logic bad, acc, drain;
    lgp_reduce #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_reduce (
        .op(op),
        .x(x),
        .z(rz),
        .bad_op(bad)
    );
    assign out_valid = state == FULL;
    assign in_ready  = !out_valid || out_ready;
    assign acc       = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= EMPTY;
        else state <= nxt;
    always_comb begin
        nxt = acc ? FULL : drain ? EMPTY : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z     <= '0;
            z_all <= 1'b0;
            z_any <= 1'b0;
            err   <= 1'b0;
        end else if (acc) begin
            z     <= rz;
            z_all <= &rz;
            z_any <= |rz;
            err   <= err | bad;
        end
    end
`ifdef LOGIC_GATE_PIPE_STATS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) txn_cnt <= '0;
        else if (acc && txn_cnt != '1) txn_cnt <= txn_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: directed and randomized checks of logic_gate_pipe against a behavioural model
module tb_logic_gate_pipe;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic        in_valid = 0, out_ready = 1, in_ready, out_valid, z_all, z_any, err;
    logic [2:0]  op = 0;
    logic [23:0] x = 0;
    logic [7:0]  z;
    logic        w_in_valid = 0, w_out_ready = 1, w_in_ready, w_out_valid, w_z, w_z_all, w_z_any, w_err;
    logic [2:0]  w_op = 0;
    logic [1:0]  w_x = 0;
`ifdef LOGIC_GATE_PIPE_STATS_EN
    logic [15:0] txn_cnt, w_txn_cnt;
`endif
    int checks = 0, errors = 0;

    logic_gate_pipe #(.WIDTH(8), .NUM_IN(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .z_all(z_all), .z_any(z_any), .err(err)
`ifdef LOGIC_GATE_PIPE_STATS_EN
        , .txn_cnt(txn_cnt)
`endif
    );

    logic_gate_pipe #(.WIDTH(1), .NUM_IN(2)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op), .x(w_x),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .z(w_z), .z_all(w_z_all), .z_any(w_z_any), .err(w_err)
`ifdef LOGIC_GATE_PIPE_STATS_EN
        , .txn_cnt(w_txn_cnt)
`endif
    );

    function automatic logic [7:0] model(input logic [2:0] o, input logic [23:0] v);
        logic [7:0] all1 = 8'hFF, any1 = 8'h00, par = 8'h00;
        for (int k = 0; k < 3; k++) begin
            all1 &= v[k*8 +: 8];
            any1 |= v[k*8 +: 8];
            par  ^= v[k*8 +: 8];
        end
        case (o)
            3'd0: return all1;
            3'd1: return any1;
            3'd2: return par;
            3'd3: return ~all1;
            3'd4: return ~any1;
            3'd5: return ~par;
            default: return 8'h00;
        endcase
    endfunction

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || z !== 8'h00 || err !== 1'b0 || z_all !== 1'b0 || z_any !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b z=%h err=%b all=%b any=%b, required 0 00 0 0 0", out_valid, z, err, z_all, z_any);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        in_valid = 1; op = 3'd1; x = 24'h0000FF;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept: out_valid=%b, required 0", out_valid);
        end
        in_valid = 0;
        rst = 0;
    endtask

    task automatic test_and_w1;
        logic [1:0] v;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                v = 2'(i - 1);
                checks++;
                if (w_out_valid !== 1'b1 || w_z !== (v[0] & v[1])) begin
                    errors++;
                    $display("FAIL w1_and[%0d]: valid=%b z=%b, required 1 %b", i - 1, w_out_valid, w_z, v[0] & v[1]);
                end
            end
            w_in_valid = i < 4;
            w_op = 3'd0;
            w_x = 2'(i);
        end
    endtask

    task automatic test_xor_nand;
        @(negedge clk);
        in_valid = 1; out_ready = 1; op = 3'd2; x = {8'hFF, 8'h3C, 8'hF0};
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || z !== 8'h33 || z_any !== 1'b1 || z_all !== 1'b0) begin
            errors++;
            $display("FAIL xor3: valid=%b z=%h any=%b all=%b, required 1 33 1 0", out_valid, z, z_any, z_all);
        end
        op = 3'd3;
        @(negedge clk);
        checks++;
        if (z !== 8'hCF) begin
            errors++;
            $display("FAIL nand3: z=%h, required cf", z);
        end
        in_valid = 0;
    endtask

    task automatic test_stall;
        @(negedge clk);
        in_valid = 1; out_ready = 1; op = 3'd1; x = 24'h00_0A_50;
        @(negedge clk);
        out_ready = 0; op = 3'd0; x = 24'hFF_FF_FF;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || z !== 8'h5A || z_all !== 1'b0 || z_any !== 1'b1) begin
                errors++;
                $display("FAIL stall[%0d]: in_ready=%b valid=%b z=%h all=%b any=%b, required 0 1 5a 0 1", i, in_ready, out_valid, z, z_all, z_any);
            end
            @(negedge clk);
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || z !== 8'hFF || z_all !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back: valid=%b z=%h all=%b, required 1 ff 1", out_valid, z, z_all);
        end
        in_valid = 0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reserved;
        @(negedge clk);
        in_valid = 1; out_ready = 1; op = 3'd6; x = 24'hFF_FF_FF;
        @(negedge clk);
        checks++;
        if (z !== 8'h00 || err !== 1'b1 || z_all !== 1'b0 || z_any !== 1'b0) begin
            errors++;
            $display("FAIL reserved_op: z=%h err=%b all=%b any=%b, required 00 1 0 0", z, err, z_all, z_any);
        end
        op = 3'd1; x = 24'h0;
        @(negedge clk);
        checks++;
        if (z !== 8'h00 || z_any !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: z=%h any=%b err=%b, required 00 0 1", z, z_any, err);
        end
        in_valid = 0;
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        in_valid = 1; out_ready = 1; op = 3'd1; x = 24'h00_00_81;
        @(negedge clk);
        in_valid = 0; out_ready = 0;
        #2;
        rst = 1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b0 || z !== 8'h00 || z_any !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b err=%b z=%h any=%b, required 0 0 00 0", out_valid, err, z, z_any);
        end
        out_ready = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_random;
        logic exp_valid = 0, exp_err = 0, rdy;
        logic [7:0] exp_z = 0;
        int exp_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== exp_valid || err !== exp_err || (exp_valid && (z !== exp_z || z_all !== (exp_z == 8'hFF) || z_any !== (exp_z != 0)))) begin
                errors++;
                $display("FAIL random[%0d]: valid=%b z=%h all=%b any=%b err=%b, required %b %h err %b", i, out_valid, z, z_all, z_any, err, exp_valid, exp_z, exp_err);
            end
`ifdef LOGIC_GATE_PIPE_STATS_EN
            checks++;
            if (txn_cnt !== 16'(exp_cnt)) begin
                errors++;
                $display("FAIL random_cnt[%0d]: txn_cnt=%0d, required %0d", i, txn_cnt, exp_cnt);
            end
`endif
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            op = 3'($urandom_range(0, 7));
            x = 24'($urandom);
            #1;
            rdy = !exp_valid || out_ready;
            checks++;
            if (in_ready !== rdy) begin
                errors++;
                $display("FAIL random_ready[%0d]: in_ready=%b, required %b", i, in_ready, rdy);
            end
            if (in_valid && rdy) begin
                exp_valid = 1;
                exp_z = model(op, x);
                exp_err |= op > 3'd5;
                exp_cnt++;
            end else if (exp_valid && out_ready) exp_valid = 0;
        end
        in_valid = 0;
    endtask

`ifdef LOGIC_GATE_PIPE_STATS_EN
    task automatic test_saturate;
        @(negedge clk);
        in_valid = 1; out_ready = 1; op = 3'd0;
        repeat (65540) @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        checks++;
        if (txn_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturate: txn_cnt=%h, required ffff", txn_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_and_w1();
        test_xor_nand();
        test_stall();
        test_reserved();
        test_async_reset();
        test_random();
`ifdef LOGIC_GATE_PIPE_STATS_EN
        test_saturate();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
